// File: rtl/vga_timing_if.sv
// vga_timing_if -- bundle between a VGA timing generator and its user.
//   cfg_we / cfg_addr / cfg_data : shadow-register write port (into the generator)
//   hs, vs                       : sync outputs at the configured polarity
//   hen, ven, de                 : horizontal / vertical / combined active
//   px, py                       : pixel coordinates while de, else 0
//   line_start, frame_start      : first-pixel pulses
//   cfg_pending                  : shadow written but not yet applied
// master = the side that writes config and consumes timing; slave = generator.
interface vga_timing_if #(
  parameter int CW = 12
);
  logic          cfg_we;
  logic [3:0]    cfg_addr;
  logic [CW-1:0] cfg_data;
  logic          hs, vs;
  logic          hen, ven, de;
  logic [CW-1:0] px, py;
  logic          line_start, frame_start;
  logic          cfg_pending;

  modport master (
    output cfg_we, cfg_addr, cfg_data,
    input  hs, vs, hen, ven, de, px, py, line_start, frame_start, cfg_pending
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data,
    output hs, vs, hen, ven, de, px, py, line_start, frame_start, cfg_pending
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- programmable VGA sync/blanking generator.
//   pclk : pixel clock, rising edge
//   rst  : synchronous reset, active low
//   bus  : vga_timing_if.slave (config write port in, timing outputs out)
// Timing comes from an active register set. Config writes go to a shadow
// set that is copied into the active set on the last pixel of a frame, so a
// frame never changes geometry halfway through.
module vga_timing_gen #(
  parameter int CW     = 12,
  parameter int HEN_D  = 800,
  parameter int HFP_D  = 56,
  parameter int HSW_D  = 120,
  parameter int HBP_D  = 64,
  parameter int VEN_D  = 600,
  parameter int VFP_D  = 37,
  parameter int VSW_D  = 6,
  parameter int VBP_D  = 23,
  parameter int HPOL_D = 1,
  parameter int VPOL_D = 1
) (
  input logic        pclk,
  input logic        rst,
  vga_timing_if.slave bus
);

  typedef struct packed {
    logic [CW-1:0] hen, hfp, hsw, hbp;
    logic [CW-1:0] ven, vfp, vsw, vbp;
    logic          vpol, hpol;
  } tset_t;

  localparam tset_t DEF = '{
    hen: CW'(HEN_D), hfp: CW'(HFP_D), hsw: CW'(HSW_D), hbp: CW'(HBP_D),
    ven: CW'(VEN_D), vfp: CW'(VFP_D), vsw: CW'(VSW_D), vbp: CW'(VBP_D),
    vpol: 1'(VPOL_D), hpol: 1'(HPOL_D)
  };

  // Reset parks the counters on the last pixel of the default frame so the
  // first cycle after release is pixel (0,0).
  localparam logic [CW-1:0] HLAST_D = CW'(HEN_D + HFP_D + HSW_D + HBP_D - 1);
  localparam logic [CW-1:0] VLAST_D = CW'(VEN_D + VFP_D + VSW_D + VBP_D - 1);

  tset_t         act, shd;
  logic          pend;
  logic [CW-1:0] hcnt, vcnt;

  logic [CW+1:0] htot_m1, vtot_m1, hs_beg, hs_end, vs_beg, vs_end, hx, vx;
  logic          h_last, v_last, f_last, wr_ok, hs_in, vs_in;

  always_comb begin
    htot_m1 = (CW+2)'(act.hen) + (CW+2)'(act.hfp) + (CW+2)'(act.hsw)
            + (CW+2)'(act.hbp) - (CW+2)'(1);
    vtot_m1 = (CW+2)'(act.ven) + (CW+2)'(act.vfp) + (CW+2)'(act.vsw)
            + (CW+2)'(act.vbp) - (CW+2)'(1);
    hs_beg  = (CW+2)'(act.hen) + (CW+2)'(act.hfp);
    hs_end  = hs_beg + (CW+2)'(act.hsw);
    vs_beg  = (CW+2)'(act.ven) + (CW+2)'(act.vfp);
    vs_end  = vs_beg + (CW+2)'(act.vsw);
    hx      = (CW+2)'(hcnt);
    vx      = (CW+2)'(vcnt);
    // Oversized totals wrap modulo 2^CW, matching the counter width.
    h_last  = (hcnt == htot_m1[CW-1:0]);
    v_last  = (vcnt == vtot_m1[CW-1:0]);
    f_last  = h_last & v_last;
    hs_in   = (hx >= hs_beg) && (hx < hs_end);
    vs_in   = (vx >= vs_beg) && (vx < vs_end);
    // Zero active width or sync width would make a degenerate frame; drop it.
    wr_ok   = bus.cfg_we && (bus.cfg_addr <= 4'd8) &&
              !((bus.cfg_data == '0) &&
                (bus.cfg_addr == 4'd0 || bus.cfg_addr == 4'd2 ||
                 bus.cfg_addr == 4'd4 || bus.cfg_addr == 4'd6));
  end

  always_ff @(posedge pclk) begin
    if (!rst) begin
      act  <= DEF;
      shd  <= DEF;
      pend <= 1'b0;
      hcnt <= HLAST_D;
      vcnt <= VLAST_D;
    end else begin
      hcnt <= h_last ? '0 : hcnt + CW'(1);
      if (h_last) vcnt <= v_last ? '0 : vcnt + CW'(1);
      // act samples the pre-edge shadow; a write on this same edge lands
      // after the copy and keeps pend set for the next frame end.
      if (f_last) begin
        act  <= shd;
        pend <= 1'b0;
      end
      if (wr_ok) begin
        pend <= 1'b1;
        case (bus.cfg_addr)
          4'd0:    shd.hen <= bus.cfg_data;
          4'd1:    shd.hfp <= bus.cfg_data;
          4'd2:    shd.hsw <= bus.cfg_data;
          4'd3:    shd.hbp <= bus.cfg_data;
          4'd4:    shd.ven <= bus.cfg_data;
          4'd5:    shd.vfp <= bus.cfg_data;
          4'd6:    shd.vsw <= bus.cfg_data;
          4'd7:    shd.vbp <= bus.cfg_data;
          default: {shd.vpol, shd.hpol} <= bus.cfg_data[1:0];
        endcase
      end
    end
  end

  always_comb begin
    bus.hen         = (hcnt < act.hen);
    bus.ven         = (vcnt < act.ven);
    bus.de          = bus.hen & bus.ven;
    bus.px          = bus.de ? hcnt : '0;
    bus.py          = bus.de ? vcnt : '0;
    bus.hs          = hs_in ? act.hpol : ~act.hpol;
    bus.vs          = vs_in ? act.vpol : ~act.vpol;
    bus.line_start  = (hcnt == '0);
    bus.frame_start = (hcnt == '0) && (vcnt == '0);
    bus.cfg_pending = pend;
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;
  localparam int CW = 12;
  localparam int DEF [9] = '{8, 2, 3, 1, 4, 1, 2, 1, 3};

  typedef struct packed {
    logic hs, vs, hen, ven, de;
    logic [CW-1:0] px, py;
    logic ls, fs, pend;
  } obs_t;

  logic pclk = 1'b0;
  logic rst  = 1'b0;
  always #5 pclk = ~pclk;

  vga_timing_if #(.CW(CW)) bus ();

  vga_timing_gen #(
    .CW(CW), .HEN_D(8), .HFP_D(2), .HSW_D(3), .HBP_D(1),
    .VEN_D(4), .VFP_D(1), .VSW_D(2), .VBP_D(1), .HPOL_D(1), .VPOL_D(1)
  ) dut (.pclk(pclk), .rst(rst), .bus(bus));

  // Reference model: position is a cycle index within the frame; the
  // row/column and every output follow from plain division and ranges.
  int   cfg_a [9];
  int   cfg_s [9];
  int   m_pend;
  int   m_t;
  obs_t exp_q [$];
  int   tests = 0;
  int   fails = 0;
  int   ncyc  = 0;

  function automatic int ftot(input int c [9]);
    return (c[0] + c[1] + c[2] + c[3]) * (c[4] + c[5] + c[6] + c[7]);
  endfunction

  function automatic obs_t expect_now();
    obs_t e;
    int htot, hc, vc, hsb, vsb;
    htot  = cfg_a[0] + cfg_a[1] + cfg_a[2] + cfg_a[3];
    hc    = m_t % htot;
    vc    = m_t / htot;
    hsb   = cfg_a[0] + cfg_a[1];
    vsb   = cfg_a[4] + cfg_a[5];
    e.hen = (hc < cfg_a[0]);
    e.ven = (vc < cfg_a[4]);
    e.de  = e.hen && e.ven;
    e.px  = e.de ? CW'(hc) : '0;
    e.py  = e.de ? CW'(vc) : '0;
    e.hs  = ((hc >= hsb) && (hc < hsb + cfg_a[2])) ? cfg_a[8][0] : !cfg_a[8][0];
    e.vs  = ((vc >= vsb) && (vc < vsb + cfg_a[6])) ? cfg_a[8][1] : !cfg_a[8][1];
    e.ls  = (hc == 0);
    e.fs  = (m_t == 0);
    e.pend = (m_pend != 0);
    return e;
  endfunction

  // One clock: drive inputs at the falling edge, advance the model across
  // the next rising edge and queue what the DUT should then show.
  task automatic cyc(input logic r, input logic we, input int a, input int d);
    @(negedge pclk);
    rst          = r;
    bus.cfg_we   = we;
    bus.cfg_addr = 4'(a);
    bus.cfg_data = CW'(d);
    if (!r) begin
      cfg_a  = DEF;
      cfg_s  = DEF;
      m_pend = 0;
      m_t    = ftot(DEF) - 1;
    end else begin
      if (m_t == ftot(cfg_a) - 1) begin
        cfg_a  = cfg_s;
        m_pend = 0;
        m_t    = 0;
      end else begin
        m_t++;
      end
      if (we && a <= 8 && !(d == 0 && (a == 0 || a == 2 || a == 4 || a == 6))) begin
        cfg_s[a] = (a == 8) ? (d & 3) : d;
        m_pend   = 1;
      end
    end
    exp_q.push_back(expect_now());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 0, 0);
  endtask

  // Monitor: every cycle the DUT presents a full output vector.
  initial begin
    obs_t e, g;
    forever begin
      @(posedge pclk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = '{bus.hs, bus.vs, bus.hen, bus.ven, bus.de, bus.px, bus.py,
              bus.line_start, bus.frame_start, bus.cfg_pending};
        tests++;
        ncyc++;
        if (g !== e) begin
          fails++;
          $display("FAIL cyc%0d {hs vs hen ven de px py ls fs pend} got %b %b %b %b %b %0d %0d %b %b %b exp %b %b %b %b %b %0d %0d %b %b %b",
                   ncyc, g.hs, g.vs, g.hen, g.ven, g.de, g.px, g.py, g.ls, g.fs, g.pend,
                   e.hs, e.vs, e.hen, e.ven, e.de, e.px, e.py, e.ls, e.fs, e.pend);
        end
      end
    end
  end

  initial begin
    int guard;
    bus.cfg_we   = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;
    cfg_a  = DEF;
    cfg_s  = DEF;
    m_pend = 0;
    m_t    = ftot(DEF) - 1;

    // Reset, release, two default frames.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 0, 0);
    idle(2 * 112);

    // Active-low sync and narrower active region, written mid-frame.
    idle(30);
    cyc(1'b1, 1'b1, 8, 0);
    cyc(1'b1, 1'b1, 0, 6);
    idle(2 * 112);

    // Ignored writes: zero sync width and out-of-range address.
    cyc(1'b1, 1'b1, 6, 0);
    cyc(1'b1, 1'b1, 12, 5);
    idle(40);

    // Write landing exactly on the last pixel of a frame.
    guard = 0;
    while (m_t != ftot(cfg_a) - 1 && guard < 2000) begin
      idle(1);
      guard++;
    end
    cyc(1'b1, 1'b1, 1, 3);
    idle(3 * 112);

    // Single-cycle reset mid-line with a write still pending.
    idle(17);
    cyc(1'b1, 1'b1, 3, 4);
    idle(5);
    cyc(1'b0, 1'b0, 0, 0);
    idle(2 * 112);

    // Random traffic: sparse writes, occasional reset.
    for (int i = 0; i < 6000; i++) begin
      logic r, we;
      int a, d;
      r  = ($urandom_range(0, 499) != 0);
      we = ($urandom_range(0, 19) == 0);
      a  = $urandom_range(0, 15);
      d  = (a == 8) ? $urandom_range(0, 3) : $urandom_range(0, 9);
      cyc(r, we, a, d);
    end

    @(posedge pclk);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
